// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared FSM encoding, button indices and minimum frame length helper
package nes_pad_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LATCH    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   function automatic int min_frame_cyc(input int latch_cyc, input int half_per, input int n_btn);
      return latch_cyc + 2 * half_per * n_btn + 2;
   endfunction
endpackage

// File: rtl/nes_pad_shift.sv
// nes_pad_shift: one pad's shadow capture, published button register and newly-pressed flags
module nes_pad_shift
   import nes_pad_pkg::*;
#(
   parameter int N_BTN = 8,
   parameter int BW    = 3
) (
   input  logic             clk_new,
   input  logic             reset,
   input  logic             i_data,
   input  logic             i_sample,
   input  logic             i_load,
   input  logic [BW-1:0]    i_bit,
   output logic [N_BTN-1:0] o_buttons,
   output logic [N_BTN-1:0] o_pressed
);
   logic [N_BTN-1:0] r_shadow, r_buttons, r_pressed;
   always_ff @(posedge clk_new) begin
      if (reset) begin
         r_shadow  <= '0;
         r_buttons <= '0;
         r_pressed <= '0;
      end else begin
         if (i_sample) r_shadow[i_bit] <= i_data;
         if (i_load) r_buttons <= r_shadow;
         r_pressed <= i_load ? r_shadow & ~r_buttons : '0;
      end
   end
   assign o_buttons = r_buttons;
   assign o_pressed = r_pressed;
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: frame-paced latch/pulse poller capturing N_CH serial pads in parallel
module nes_pad_reader
   import nes_pad_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int N_BTN      = 8,
   parameter int LATCH_CYC  = 2,
   parameter int HALF_PER   = 1,
   parameter int FRAME_CYC  = 1634,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk_new,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [N_CH-1:0]       data,
   output logic                  latch,
   output logic                  pulse,
   output logic [N_CH*N_BTN-1:0] buttons,
   output logic [N_CH*N_BTN-1:0] pressed,
   output logic                  frame_valid,
   output logic                  busy
);
   localparam int CW = $clog2(FRAME_CYC);
   localparam int BW = N_BTN > 1 ? $clog2(N_BTN) : 1;
   localparam int PW = $clog2((LATCH_CYC > HALF_PER ? LATCH_CYC : HALF_PER) + 1);
   if (FRAME_CYC < min_frame_cyc(LATCH_CYC, HALF_PER, N_BTN)) begin : g_frame_chk
      $error("FRAME_CYC too short for LATCH_CYC, HALF_PER and N_BTN");
   end
   state_t        r_state, w_nxt;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_ph;
   logic [BW-1:0] r_bit;
   logic          r_latch, r_pulse;
   logic          w_ph_end, w_last, w_sample, w_load;
   assign w_ph_end = r_ph == PW'(r_state == LATCH ? LATCH_CYC - 1 : HALF_PER - 1);
   assign w_last   = r_bit == BW'(N_BTN - 1);
   assign w_sample = r_state == SHIFT_LO && w_ph_end;
   assign w_load   = r_state == SHIFT_HI && w_ph_end && w_last;
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:     if (r_cnt == '0 && enable) w_nxt = LATCH;
         LATCH:    if (w_ph_end) w_nxt = SHIFT_LO;
         SHIFT_LO: if (w_ph_end) w_nxt = SHIFT_HI;
         SHIFT_HI: if (w_ph_end) w_nxt = w_last ? DONE : SHIFT_LO;
         default:  w_nxt = IDLE;
      endcase
   end
   // latch/pulse flops are loaded from the next state so they line up with r_state
   always_ff @(posedge clk_new) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ph    <= '0;
         r_bit   <= '0;
         r_latch <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= r_cnt == CW'(FRAME_CYC - 1) ? '0 : r_cnt + 1'b1;
         r_ph    <= w_nxt != r_state ? '0 : r_ph + 1'b1;
         r_bit   <= r_state == LATCH ? '0 : (r_state == SHIFT_HI && w_ph_end && !w_last) ? r_bit + 1'b1 : r_bit;
         r_latch <= w_nxt == LATCH;
         r_pulse <= w_nxt == SHIFT_HI;
      end
   end
   assign latch       = r_latch;
   assign pulse       = r_pulse;
   assign frame_valid = r_state == DONE;
   assign busy        = r_state != IDLE;
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      nes_pad_shift #(.N_BTN(N_BTN), .BW(BW)) u_shift (
         .clk_new  (clk_new),
         .reset    (reset),
         .i_data   (data[i] ^ (ACTIVE_LOW != 0)),
         .i_sample (w_sample),
         .i_load   (w_load),
         .i_bit    (r_bit),
         .o_buttons(buttons[i*N_BTN +: N_BTN]),
         .o_pressed(pressed[i*N_BTN +: N_BTN])
      );
   end
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: directed checks of poll timing, capture, edges, reset and enable on two configurations
module tb_nes_pad_reader;
   logic        clk_new = 1'b0;
   logic        rst_a, en_a, rst_b, en_b;
   logic [1:0]  data_a;
   logic [0:0]  data_b;
   logic        latch_a, pulse_a, fv_a, busy_a, latch_b, pulse_b, fv_b, busy_b;
   logic [15:0] buttons_a, pressed_a;
   logic [11:0] buttons_b, pressed_b;
   logic [7:0]  pat0 = 8'hFE, pat1 = 8'hFF, sh0 = 8'hFF, sh1 = 8'hFF;
   logic [11:0] patb = 12'hA5C, shb = 12'hFFF;
   int          c = 0, n_cmp = 0, n_err = 0;

   always #5 clk_new = ~clk_new;

   nes_pad_reader u_dut_a (
      .clk_new(clk_new), .reset(rst_a), .enable(en_a), .data(data_a),
      .latch(latch_a), .pulse(pulse_a), .buttons(buttons_a), .pressed(pressed_a),
      .frame_valid(fv_a), .busy(busy_a)
   );

   nes_pad_reader #(.N_CH(1), .N_BTN(12), .HALF_PER(3), .FRAME_CYC(200)) u_dut_b (
      .clk_new(clk_new), .reset(rst_b), .enable(en_b), .data(data_b),
      .latch(latch_b), .pulse(pulse_b), .buttons(buttons_b), .pressed(pressed_b),
      .frame_valid(fv_b), .busy(busy_b)
   );

   // pad models: parallel load on latch, shift toward the wire on pulse rise, idle-high fill
   always @(posedge latch_a or posedge pulse_a) begin
      sh0 <= latch_a ? pat0 : {1'b1, sh0[7:1]};
      sh1 <= latch_a ? pat1 : {1'b1, sh1[7:1]};
   end
   always @(posedge latch_b or posedge pulse_b) shb <= latch_b ? patb : {1'b1, shb[11:1]};
   assign data_a = {sh1[0], sh0[0]};
   assign data_b = shb[0:0];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h (t=%0t c=%0d)", tag, got, exp, $time, c);
      end
   endtask

   task automatic tick();
      @(posedge clk_new);
      #1;
      c++;
   endtask

   task automatic wait_to(input int t);
      while (c < t) tick();
   endtask

   task automatic start_chk(input int base);
      wait_to(base);
      chk("latch_go", latch_a, 1);
      chk("busy_go", busy_a, 1);
   endtask

   task automatic end_chk(input int base, input logic [15:0] eb, input logic [15:0] ep);
      wait_to(base + 18);
      chk("fv", fv_a, 1);
      chk("btn", buttons_a, eb);
      chk("prs", pressed_a, ep);
      tick();
      chk("prs_clr", pressed_a, 0);
      chk("busy_end", busy_a, 0);
      chk("btn_hold", buttons_a, eb);
   endtask

   initial begin
      logic [3:0] e;
      rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
      repeat (3) @(posedge clk_new);
      #1;
      chk("rst_map", {latch_a, pulse_a, fv_a, busy_a}, 0);
      chk("rst_btn", buttons_a, 0);
      chk("rst_prs", pressed_a, 0);
      rst_a = 1'b0;
      tick();
      c = 0;
      for (int k = 0; k < 20; k++) begin
         e = {k < 2, k >= 3 && k <= 17 && (k % 2 == 1), k == 18, k <= 18};
         chk("map_a", {latch_a, pulse_a, fv_a, busy_a}, e);
         if (k == 18) begin
            chk("f1_btn", buttons_a, 16'h0001);
            chk("f1_prs", pressed_a, 16'h0001);
         end
         if (k == 19) chk("f1_prs_clr", pressed_a, 0);
         tick();
      end
      wait_to(1633);
      chk("latch_pre", latch_a, 0);
      start_chk(1634);
      end_chk(1634, 16'h0001, 16'h0000);
      pat0 = 8'hFF;
      pat1 = 8'hE7;
      wait_to(3267);
      chk("latch_pre2", latch_a, 0);
      start_chk(3268);
      end_chk(3268, 16'h1800, 16'h1800);
      wait_to(4912);
      rst_a = 1'b1;
      tick();
      chk("rst_mid_map", {latch_a, pulse_a, fv_a, busy_a}, 0);
      chk("rst_mid_btn", buttons_a, 0);
      chk("rst_mid_prs", pressed_a, 0);
      rst_a = 1'b0;
      tick();
      start_chk(4914);
      end_chk(4914, 16'h1800, 16'h1800);
      start_chk(6548);
      wait_to(6553);
      en_a = 1'b0;
      end_chk(6548, 16'h1800, 16'h0000);
      wait_to(8182);
      chk("no_latch", latch_a, 0);
      tick();
      chk("no_busy", busy_a, 0);
      wait_to(8548);
      en_a = 1'b1;
      wait_to(9815);
      chk("latch_wait", latch_a, 0);
      start_chk(9816);
      end_chk(9816, 16'h1800, 16'h0000);
      rst_b = 1'b0;
      tick();
      c = 0;
      for (int k = 0; k < 76; k++) begin
         e = {k < 2, k >= 2 && k <= 73 && ((k - 2) % 6) >= 3, k == 74, k <= 74};
         chk("map_b", {latch_b, pulse_b, fv_b, busy_b}, e);
         if (k == 74) begin
            chk("b_btn", buttons_b, 12'h5A3);
            chk("b_prs", pressed_b, 12'h5A3);
         end
         if (k == 75) chk("b_prs_clr", pressed_b, 0);
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
